// File: rtl/multibit_serial_comparator_if.sv
// Start/busy/done handshake and operand/result bus of the serial magnitude comparator.
// The optional sgn request bit exists only when SIGNED_CMP_EN is defined.
interface multibit_serial_comparator_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef SIGNED_CMP_EN
    logic             sgn;
`endif
    logic             busy;
    logic             done;
    logic [2:0]       Y;

    // Controller side: issues requests, observes status and result.
    modport master (
`ifdef SIGNED_CMP_EN
        output sgn,
`endif
        output start, A, B,
        input  busy, done, Y
    );

    // Comparator side.
    modport slave (
`ifdef SIGNED_CMP_EN
        input  sgn,
`endif
        input  start, A, B,
        output busy, done, Y
    );
endinterface

// File: rtl/multibit_serial_comparator.sv
// Digit-serial WIDTH-bit magnitude comparator, MSB digit first, with early exit.
// Result is one-hot {gt,lt,eq}. Define SIGNED_CMP_EN to add the two's-complement sgn request.
module multibit_serial_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    multibit_serial_comparator_if.slave           bus
);
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    localparam logic [2:0] Y_GT = 3'b100;
    localparam logic [2:0] Y_LT = 3'b010;
    localparam logic [2:0] Y_EQ = 3'b001;

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("multibit_serial_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_COMP = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_sa, w_sa_nxt;
    logic [WIDTH-1:0]   r_sb, w_sb_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic [2:0]         r_y, w_y_nxt;

    logic [DIGIT-1:0]   w_da;
    logic [DIGIT-1:0]   w_db;
    logic               w_inv;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
`ifdef SIGNED_CMP_EN
    assign w_inv = bus.sgn;
`else
    assign w_inv = 1'b0;
`endif

    assign w_da = r_sa[WIDTH-1 -: DIGIT];
    assign w_db = r_sb[WIDTH-1 -: DIGIT];

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_sa_nxt    = r_sa;
        w_sb_nxt    = r_sb;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_y_nxt     = r_y;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_sa_nxt    = {bus.A[WIDTH-1] ^ w_inv, bus.A[WIDTH-2:0]};
                    w_sb_nxt    = {bus.B[WIDTH-1] ^ w_inv, bus.B[WIDTH-2:0]};
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_COMP;
                end
            end

            ST_COMP: begin
                if (w_da > w_db) begin
                    w_y_nxt     = Y_GT;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (w_da < w_db) begin
                    w_y_nxt     = Y_LT;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == LAST_CNT) begin
                    w_y_nxt     = Y_EQ;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_sa_nxt  = r_sa << DIGIT;
                    w_sb_nxt  = r_sb << DIGIT;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values, matching the hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            // NOTE: operand registers are cleared too; they are few flops, not a memory array, so reset is cheap and keeps them deterministic.
            r_sa    <= '0;
            r_sb    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_y     <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_sa    <= w_sa_nxt;
            r_sb    <= w_sb_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_y     <= w_y_nxt;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.Y    = r_y;
endmodule
